// File: rtl/mmr_event_encoder.sv
// Collects per-MMR service events, picks one round-robin and presents
// BASE_ADDR + index to the CPU over a valid/ready handshake.
module mmr_event_encoder #(
  parameter int unsigned BASE_ADDR = 1025,
  parameter int unsigned N_MMR     = 75,
  parameter int unsigned IDX_W     = 7,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_MMR-1:0]  evt_in,
  input  logic [N_MMR-1:0]  evt_mask,
  input  logic              ready,
  input  logic              lost_clr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic              pend_any,
  output logic              lost
);

  localparam int unsigned SUM_W = IDX_W + 1;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [N_MMR-1:0] pend, pend_nxt, elig, clr_bit;
  logic [IDX_W-1:0] ptr, cur_idx, sel_idx;
  logic [SUM_W-1:0] scan_idx;
  logic             sel_hit, take, accept, lost_set;

  assign elig = pend & evt_mask;

  // Round-robin search: first eligible index scanning ptr, ptr+1, ... wrapping at N_MMR
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < int'(N_MMR); k++) begin
      scan_idx = SUM_W'(ptr) + SUM_W'(k);
      if (scan_idx >= SUM_W'(N_MMR)) scan_idx = scan_idx - SUM_W'(N_MMR);
      if (!sel_hit && elig[scan_idx]) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(scan_idx);
      end
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_hit) begin
          take      = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new event on a bit being taken this cycle stays pending and counts as lost
  always_comb begin
    clr_bit = '0;
    if (take) clr_bit[sel_idx] = 1'b1;
    pend_nxt = (pend & ~clr_bit) | evt_in;
    lost_set = |(evt_in & (pend | clr_bit));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      ptr      <= '0;
      cur_idx  <= '0;
      valid    <= 1'b0;
      addr_out <= '0;
      pend_any <= 1'b0;
      lost     <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      pend_any <= |(pend_nxt & evt_mask);
      valid    <= (state_nxt == PRESENT);
      if (take) begin
        cur_idx  <= sel_idx;
        addr_out <= ADDR_W'(BASE_ADDR) + ADDR_W'(sel_idx);
      end
      if (accept) begin
        ptr <= (cur_idx == IDX_W'(N_MMR - 1)) ? '0 : cur_idx + IDX_W'(1);
      end
      if (lost_set)      lost <= 1'b1;
      else if (lost_clr) lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmr_event_encoder.sv
// Directed and randomized bench for mmr_event_encoder against a
// cycle-level reference model built from arrays and modular arithmetic.
module tb_mmr_event_encoder;

  localparam int N    = 75;
  localparam int BASE = 1025;
  localparam logic [N-1:0] FULL = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  evt_in = '0;
  logic [N-1:0]  evt_mask = '1;
  logic          ready = 1'b1;
  logic          lost_clr = 1'b0;
  logic          valid;
  logic [11:0]   addr_out;
  logic          pend_any;
  logic          lost;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [N-1:0] m_pend;
  int           m_ptr, m_cur, m_addr;
  logic         m_busy, m_lost, m_pany;

  mmr_event_encoder dut (
    .clk(clk), .rst(rst), .evt_in(evt_in), .evt_mask(evt_mask),
    .ready(ready), .lost_clr(lost_clr), .valid(valid), .addr_out(addr_out),
    .pend_any(pend_any), .lost(lost)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_cur = 0; m_addr = 0;
    m_busy = 1'b0; m_lost = 1'b0; m_pany = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".valid"}, int'(valid), int'(m_busy));
    chk({ctx, ".addr"}, int'(addr_out), m_addr);
    chk({ctx, ".lost"}, int'(lost), int'(m_lost));
    chk({ctx, ".pend_any"}, int'(pend_any), int'(m_pany));
  endtask

  // One clock: drive inputs, advance the model, check after the edge
  task automatic step(input logic [N-1:0] e, input logic [N-1:0] m,
                      input logic r, input logic lc, input string ctx);
    logic [N-1:0] clr;
    int   sel;
    evt_in = e; evt_mask = m; ready = r; lost_clr = lc;
    clr = '0;
    if (m_busy) begin
      if (r) begin
        m_busy = 1'b0;
        m_ptr  = (m_cur + 1) % N;
      end
    end else begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && m_pend[(m_ptr + k) % N] && m[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      end
      if (sel >= 0) begin
        m_busy = 1'b1;
        m_cur  = sel;
        m_addr = BASE + sel;
        clr[sel] = 1'b1;
      end
    end
    if ((e & (m_pend | clr)) != '0) m_lost = 1'b1;
    else if (lc)                    m_lost = 1'b0;
    m_pend = (m_pend & ~clr) | e;
    m_pany = |(m_pend & m);
    @(posedge clk); #1;
    check_all(ctx);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; evt_in = FULL; ready = 1'b1; lost_clr = 1'b0; evt_mask = FULL;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0; evt_in = '0;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] e, msk;
    model_reset();

    // reset with all events asserted: everything discarded
    do_reset(3);
    chk("rst.valid", int'(valid), 0);
    chk("rst.addr", int'(addr_out), 0);
    chk("rst.lost", int'(lost), 0);
    chk("rst.pend_any", int'(pend_any), 0);
    repeat (3) step('0, FULL, 1'b1, 1'b0, "post_rst");

    // boundary indices
    step(oh(0), FULL, 1'b1, 1'b0, "b0.pulse");
    step('0, FULL, 1'b1, 1'b0, "b0.sel");
    chk("b0.valid", int'(valid), 1);
    chk("b0.addr", int'(addr_out), 1025);
    step('0, FULL, 1'b1, 1'b0, "b0.acc");
    step(oh(74), FULL, 1'b1, 1'b0, "b74.pulse");
    step('0, FULL, 1'b1, 1'b0, "b74.sel");
    chk("b74.addr", int'(addr_out), 1099);
    step('0, FULL, 1'b1, 1'b0, "b74.acc");

    // sweep every index
    for (int i = 0; i < N; i++) begin
      step(oh(i), FULL, 1'b1, 1'b0, "sweep.pulse");
      step('0, FULL, 1'b1, 1'b0, "sweep.sel");
      chk("sweep.addr", int'(addr_out), BASE + i);
      step('0, FULL, 1'b1, 1'b0, "sweep.acc");
    end

    // round robin, ptr back at 0 after index 74
    step(oh(3) | oh(10), FULL, 1'b1, 1'b0, "rr1.pulse");
    step('0, FULL, 1'b1, 1'b0, "rr1.a");
    chk("rr1.first", int'(addr_out), 1028);
    step('0, FULL, 1'b1, 1'b0, "rr1.acc");
    step('0, FULL, 1'b1, 1'b0, "rr1.b");
    chk("rr1.second", int'(addr_out), 1035);
    step('0, FULL, 1'b1, 1'b0, "rr1.acc2");
    step(oh(3) | oh(10), FULL, 1'b1, 1'b0, "rr2.pulse");
    step('0, FULL, 1'b1, 1'b0, "rr2.a");
    chk("rr2.wrap_first", int'(addr_out), 1028);
    step('0, FULL, 1'b1, 1'b0, "rr2.acc");
    step('0, FULL, 1'b1, 1'b0, "rr2.b");
    chk("rr2.second", int'(addr_out), 1035);
    step('0, FULL, 1'b1, 1'b0, "rr2.acc2");
    step(oh(73), FULL, 1'b1, 1'b0, "rr3.setptr");
    step('0, FULL, 1'b1, 1'b0, "rr3.sel73");
    step('0, FULL, 1'b1, 1'b0, "rr3.acc73");
    step(oh(74) | oh(0), FULL, 1'b1, 1'b0, "rr3.pulse");
    step('0, FULL, 1'b1, 1'b0, "rr3.a");
    chk("rr3.first", int'(addr_out), 1099);
    step('0, FULL, 1'b1, 1'b0, "rr3.acc");
    step('0, FULL, 1'b1, 1'b0, "rr3.b");
    chk("rr3.second", int'(addr_out), 1025);
    step('0, FULL, 1'b1, 1'b0, "rr3.acc2");

    // backpressure with a re-arm of the presented index
    step(oh(5), FULL, 1'b0, 1'b0, "bp.pulse");
    step('0, FULL, 1'b0, 1'b0, "bp.sel");
    for (int c = 0; c < 5; c++) begin
      step((c == 2) ? oh(5) : '0, FULL, 1'b0, 1'b0, "bp.hold");
      chk("bp.hold_valid", int'(valid), 1);
      chk("bp.hold_addr", int'(addr_out), 1030);
    end
    step('0, FULL, 1'b1, 1'b0, "bp.acc");
    step('0, FULL, 1'b1, 1'b0, "bp.again");
    chk("bp.again_addr", int'(addr_out), 1030);
    chk("bp.lost", int'(lost), 0);
    step('0, FULL, 1'b1, 1'b0, "bp.acc2");

    // coalesce: double event held off by the mask
    msk = FULL & ~oh(7);
    step(oh(7), msk, 1'b1, 1'b0, "lost.p1");
    step('0, msk, 1'b1, 1'b0, "lost.gap");
    step(oh(7), msk, 1'b1, 1'b0, "lost.p2");
    chk("lost.set", int'(lost), 1);
    step('0, FULL, 1'b1, 1'b0, "lost.sel");
    chk("lost.addr", int'(addr_out), 1032);
    for (int c = 0; c < 4; c++) step('0, FULL, 1'b1, 1'b0, "lost.once");
    step('0, FULL, 1'b1, 1'b1, "lost.clr");
    chk("lost.cleared", int'(lost), 0);
    step(oh(8), FULL, 1'b1, 1'b0, "lost.q1");
    step(oh(8), FULL, 1'b1, 1'b1, "lost.q2_clr");
    chk("lost.set_wins", int'(lost), 1);
    for (int c = 0; c < 4; c++) step('0, FULL, 1'b1, 1'b1, "lost.flush");

    // mask holds an event pending without selecting it
    msk = FULL & ~oh(20);
    step(oh(20), msk, 1'b1, 1'b0, "mask.pulse");
    for (int c = 0; c < 3; c++) begin
      step('0, msk, 1'b1, 1'b0, "mask.hold");
      chk("mask.no_valid", int'(valid), 0);
      chk("mask.no_pend", int'(pend_any), 0);
    end
    step('0, FULL, 1'b1, 1'b0, "mask.open");
    chk("mask.valid", int'(valid), 1);
    chk("mask.addr", int'(addr_out), 1045);
    step('0, FULL, 1'b1, 1'b0, "mask.acc");

    // randomized traffic with an occasional mid-handshake reset
    for (int c = 0; c < 600; c++) begin
      e = '0;
      msk = FULL;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 39) == 0) e[b] = 1'b1;
        if ($urandom_range(0, 9) == 0)  msk[b] = 1'b0;
      end
      if (c == 300) begin
        do_reset(2);
        check_all("rnd.rst");
      end
      step(e, msk, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
